q_extractor_mc: RTL and testbench
=================================

# q_extractor_mc

Parametrised multi-channel charge extractor, the next generation of the fixed 4-channel Q extractor. Sits downstream of `fir_trig` and takes its filtered samples and per-channel time-over-threshold bits. On a coincidence trigger it integrates a pre-triggered window of filtered samples for every channel at once, then streams one signed charge word per channel over a valid/ready handshake. Adds a majority coincidence condition, configurable window and pre-trigger depth, output backpressure, hold-off, and trigger accounting.

## Interface
- `N_CH`, 4: number of channels.
- `IN_W`, 31: filtered sample width, two's-complement signed.
- `PRE`, 4: pre-trigger depth in valid samples (0..64).
- `WIN_LEN`, 16: integration window length in valid samples (≥1).
- `MAJ`, 1: minimum number of asserted `tot` bits that forms a coincidence (1..N_CH).
- `HOLDOFF`, 8: dead cycles after the last output word (0 allowed).
- `SUM_W`, IN_W+$clog2(WIN_LEN)+1: charge width. Derived; never overridden.
- `clk`  in  1  clock (60 MHz system clock).
- `reset`  in  1  asynchronous, active-high reset.
- `tot`  in  N_CH  per-channel time-over-threshold bits.
- `in_data`  in  N_CH*IN_W  filtered samples; channel k occupies bits [k*IN_W +: IN_W].
- `in_valid`  in  1  qualifies `in_data`.
- `out_valid`  out  1  charge word available.
- `out_ready`  in  1  consumer accepts the word.
- `out_ch`  out  $clog2(N_CH) (min 1)  channel index of the current word.
- `out_q`  out  SUM_W  signed integrated charge.
- `out_last`  out  1  current word is channel N_CH-1.
- `busy`  out  1  state ≠ IDLE.
- `trig_cnt`  out  16  accepted triggers; wraps modulo 2^16.
- `lost_cnt`  out  16  triggers rejected while busy; saturates at 0xFFFF.

## Operation
- Delay line: each channel's sample advances only when `in_valid`=1. Its output is the sample received PRE valid samples earlier. Contents are zero after reset. With PRE=0 the delay line is a pass-through.
- Coincidence: `coinc` = popcount(`tot`) ≥ MAJ. `coinc_d` is `coinc` registered every cycle in every state. A trigger edge is `coinc & ~coinc_d`.
- FSM states: IDLE, INTEG, DRAIN, HOLD.
- IDLE:
  - On a trigger edge, go to INTEG and increment `trig_cnt`.
  - In the same cycle, load the accumulators with the delayed sample if `in_valid`=1 (sample counter = 1); otherwise load 0 (counter = 0).
- INTEG:
  - Each `in_valid` cycle, add the sign-extended delayed sample to each accumulator and increment the counter.
  - When the counter reaches WIN_LEN, go to DRAIN with `out_ch`=0.
  - If WIN_LEN=1 and the first sample was taken in IDLE, go directly from IDLE to DRAIN.
- DRAIN:
  - `out_valid`=1 and `out_q` = accumulator[`out_ch`].
  - A transfer occurs when `out_valid & out_ready`; `out_ch` then increments.
  - The transfer with `out_last`=1 moves to HOLD (or to IDLE if HOLDOFF=0).
  - `out_q` and `out_ch` are stable while `out_ready`=0.
- HOLD: counts HOLDOFF cycles, then returns to IDLE.
- Lost triggers: a trigger edge in INTEG, DRAIN or HOLD increments `lost_cnt` and is otherwise ignored. A coincidence still high on re-entry to IDLE does not trigger; a fresh rising edge is required.
- Arithmetic: SUM_W is sized so the sum cannot overflow; no saturation logic.
- Reset: asynchronous, takes effect immediately. All of the following go to 0: outputs, FSM (IDLE), accumulators, counters, delay line, `coinc_d`. Reset during any state aborts the event with no partial output.

## Timing
- With continuous `in_valid`, the trigger edge at cycle T accumulates samples at T..T+WIN_LEN-1.
- `out_valid` rises at T+WIN_LEN. With `out_ready`=1, the words appear at T+WIN_LEN .. T+WIN_LEN+N_CH-1.
- HOLD occupies the next HOLDOFF cycles; IDLE is re-entered at T+WIN_LEN+N_CH+HOLDOFF.
- Window content: with continuous `in_valid`, the window holds samples from PRE before the trigger sample through WIN_LEN-PRE-1 after it.
- `in_valid` gaps stretch INTEG; they do not shorten the window.
- Every output is registered.

## Structure
- Shared package `q_ext_pkg`:
  - FSM state enum.
  - `popcount` function.
  - Helper functions for SUM_W and `out_ch` width.
- One sub-module, `q_delay_line`: parameters WIDTH and DEPTH, with an enable input. Instantiated once per channel.

## Test plan
Defaults used: N_CH=4, PRE=4, WIN_LEN=16, MAJ=1, HOLDOFF=8.
- Basic drain: channel k held at constant k+1, continuous valid, single `tot[0]` pulse at T -> `out_q` = 16, 32, 48, 64 for ch0..3 at T+16..T+19; `out_last` on ch3; `trig_cnt`=1.
- Pre-trigger edge: ch0 impulse of 100 at 4 samples before the trigger -> Q0=100. Impulse at 5 samples before -> Q0=0.
- Gaps and backpressure: `in_valid` toggling 1/0 -> `out_valid` at T+31 with identical sums. `out_ready` low for 10 cycles mid-DRAIN -> `out_q`/`out_ch` held, all 4 words delivered.
- Lost and re-arm: second `tot` edge during INTEG and another during HOLD -> `lost_cnt`=2, `trig_cnt`=1. Coincidence held high through return to IDLE -> no new trigger.
- Negative full scale: ch1 = -2^30 constant -> Q1 = -2^34, exact in 36 bits, sign correct.
- Majority and reset: with MAJ=2, `tot`=4'b0001 -> no trigger; `tot`=4'b0110 -> trigger. `reset` asserted mid-DRAIN -> `out_valid`, `busy`, counters 0 at once; next event sums are correct.

Source files
------------

// File: rtl/q_ext_pkg.sv
// Shared types and sizing helpers for the multi-channel charge extractor.
package q_ext_pkg;

  typedef enum logic [1:0] {S_IDLE, S_INTEG, S_DRAIN, S_HOLD} state_t;

  function automatic int popcount(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) n = n + 1;
    end
    return n;
  endfunction

  function automatic int sum_width(input int in_w, input int win_len);
    return in_w + $clog2(win_len) + 1;
  endfunction

  function automatic int ch_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/q_delay_line.sv
// Enable-gated shift register: dout is the sample accepted DEPTH enables ago.
// DEPTH=0 degenerates to a wire; contents clear on reset.
module q_delay_line #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    assign dout = din;
  end else begin : g_sr
    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else if (en) begin
        sr[0] <= din;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end

    assign dout = sr[DEPTH-1];
  end

endmodule

// File: rtl/q_extractor_mc.sv
// Coincidence-triggered pre-triggered window integrator; charge words leave WIN_LEN valid samples after the trigger.
// Words stream one channel per out_ready transfer and hold steady while out_ready is low.
module q_extractor_mc
  import q_ext_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int IN_W    = 31,
  parameter int PRE     = 4,
  parameter int WIN_LEN = 16,
  parameter int MAJ     = 1,
  parameter int HOLDOFF = 8,
  localparam int SUM_W  = sum_width(IN_W, WIN_LEN),
  localparam int CH_W   = ch_width(N_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         tot,
  input  logic [N_CH*IN_W-1:0]    in_data,
  input  logic                    in_valid,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH_W-1:0]         out_ch,
  output logic signed [SUM_W-1:0] out_q,
  output logic                    out_last,
  output logic                    busy,
  output logic [15:0]             trig_cnt,
  output logic [15:0]             lost_cnt
);

  localparam int CNT_W = $clog2(WIN_LEN + 1);
  localparam int HLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  state_t                  state;
  logic                    coinc, coinc_d, trig_edge;
  logic [CNT_W-1:0]        cnt;
  logic [HLD_W-1:0]        hold_cnt;
  logic [CH_W-1:0]         next_ch;
  logic [IN_W-1:0]         dly     [N_CH];
  logic signed [SUM_W-1:0] ext     [N_CH];
  logic signed [SUM_W-1:0] acc     [N_CH];
  logic signed [SUM_W-1:0] acc_add [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    q_delay_line #(.WIDTH(IN_W), .DEPTH(PRE)) u_dly (
      .clk  (clk),
      .reset(reset),
      .en   (in_valid),
      .din  (in_data[k*IN_W +: IN_W]),
      .dout (dly[k])
    );
    assign ext[k]     = {{(SUM_W-IN_W){dly[k][IN_W-1]}}, dly[k]};
    assign acc_add[k] = acc[k] + ext[k];
  end

  assign coinc     = popcount(64'(tot)) >= MAJ;
  assign trig_edge = coinc & ~coinc_d;
  assign next_ch   = out_ch + CH_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      coinc_d   <= 1'b0;
      cnt       <= '0;
      hold_cnt  <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_q     <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      trig_cnt  <= '0;
      lost_cnt  <= '0;
      for (int k = 0; k < N_CH; k++) acc[k] <= '0;
    end else begin
      coinc_d <= coinc;
      if (trig_edge && state != S_IDLE && lost_cnt != 16'hFFFF)
        lost_cnt <= lost_cnt + 16'd1;

      case (state)
        S_IDLE: begin
          if (trig_edge) begin
            trig_cnt <= trig_cnt + 16'd1;
            busy     <= 1'b1;
            for (int k = 0; k < N_CH; k++) acc[k] <= in_valid ? ext[k] : '0;
            cnt <= in_valid ? CNT_W'(1) : '0;
            // A one-sample window is already complete on the trigger cycle.
            if (in_valid && WIN_LEN == 1) begin
              state     <= S_DRAIN;
              out_valid <= 1'b1;
              out_ch    <= '0;
              out_q     <= ext[0];
              out_last  <= (N_CH == 1);
            end else begin
              state <= S_INTEG;
            end
          end
        end

        S_INTEG: begin
          if (in_valid) begin
            for (int k = 0; k < N_CH; k++) acc[k] <= acc_add[k];
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIN_LEN - 1)) begin
              state     <= S_DRAIN;
              out_valid <= 1'b1;
              out_ch    <= '0;
              out_q     <= acc_add[0];
              out_last  <= (N_CH == 1);
            end
          end
        end

        S_DRAIN: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_ch    <= '0;
              hold_cnt  <= '0;
              if (HOLDOFF == 0) begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end else begin
                state <= S_HOLD;
              end
            end else begin
              out_ch   <= next_ch;
              out_q    <= acc[next_ch];
              out_last <= (next_ch == CH_W'(N_CH - 1));
            end
          end
        end

        S_HOLD: begin
          if (hold_cnt == HLD_W'(HOLDOFF - 1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HLD_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_q_extractor_mc.sv
// Randomized bench for q_extractor_mc against a window-sum reference built from the full sample history.
module tb_q_extractor_mc;

  localparam int N_CH    = 4;
  localparam int IN_W    = 31;
  localparam int PRE     = 4;
  localparam int WIN_LEN = 16;
  localparam int MAJ     = 1;
  localparam int HOLDOFF = 8;
  localparam int SUM_W   = IN_W + $clog2(WIN_LEN) + 1;
  localparam int NH      = 8192;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic [N_CH-1:0]         tot = '0;
  logic [N_CH*IN_W-1:0]    in_data = '0;
  logic                    in_valid = 1'b0;
  logic                    out_ready = 1'b1;
  logic                    out_valid, out_last, busy;
  logic [1:0]              out_ch;
  logic signed [SUM_W-1:0] out_q;
  logic [15:0]             trig_cnt, lost_cnt;

  logic                    out_valid2, out_last2, busy2;
  logic [1:0]              out_ch2;
  logic signed [SUM_W-1:0] out_q2;
  logic [15:0]             trig_cnt2, lost_cnt2;

  q_extractor_mc #(.N_CH(N_CH), .IN_W(IN_W), .PRE(PRE), .WIN_LEN(WIN_LEN),
                   .MAJ(MAJ), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .reset(reset), .tot(tot), .in_data(in_data), .in_valid(in_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_q(out_q),
    .out_last(out_last), .busy(busy), .trig_cnt(trig_cnt), .lost_cnt(lost_cnt)
  );

  q_extractor_mc #(.N_CH(N_CH), .IN_W(IN_W), .PRE(PRE), .WIN_LEN(WIN_LEN),
                   .MAJ(2), .HOLDOFF(HOLDOFF)) dut_maj2 (
    .clk(clk), .reset(reset), .tot(tot), .in_data(in_data), .in_valid(in_valid),
    .out_valid(out_valid2), .out_ready(out_ready), .out_ch(out_ch2), .out_q(out_q2),
    .out_last(out_last2), .busy(busy2), .trig_cnt(trig_cnt2), .lost_cnt(lost_cnt2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: every valid sample is kept; a charge is the plain sum over its window.
  typedef enum int {P_IDLE, P_INT, P_OUT, P_HOLD} ph_t;
  ph_t    m_ph = P_IDLE;
  bit     m_cd = 1'b0;
  int     nv = 0, base = 0, m_ts = 0, m_got = 0, m_idx = 0, m_hold = 0;
  int     m_trig = 0, m_lost = 0;
  longint m_q [N_CH];
  longint hist [N_CH][NH];

  int vmode = 0, rmode = 0, dmode = 0, imp = 0;

  function automatic void start_out();
    for (int k = 0; k < N_CH; k++) begin
      longint s = 0;
      for (int i = m_ts - PRE; i < m_ts - PRE + WIN_LEN; i++)
        if (i >= base) s += hist[k][i];
      m_q[k] = s;
    end
    m_ph  = P_OUT;
    m_idx = 0;
  endfunction

  function automatic void model_edge();
    bit co, edge_;
    co    = $countones(tot) >= MAJ;
    edge_ = co && !m_cd;
    m_cd  = co;
    if (edge_ && m_ph != P_IDLE && m_lost < 65535) m_lost++;
    if (in_valid && nv < NH) begin
      for (int k = 0; k < N_CH; k++)
        hist[k][nv] = longint'($signed(in_data[k*IN_W +: IN_W]));
      nv++;
    end
    case (m_ph)
      P_IDLE: if (edge_) begin
        m_trig = (m_trig + 1) % 65536;
        m_ts   = in_valid ? nv - 1 : nv;
        m_got  = in_valid ? 1 : 0;
        m_ph   = P_INT;
        if (m_got == WIN_LEN) start_out();
      end
      P_INT: if (in_valid) begin
        m_got++;
        if (m_got == WIN_LEN) start_out();
      end
      P_OUT: if (out_ready) begin
        m_idx++;
        if (m_idx == N_CH) begin
          if (HOLDOFF == 0) m_ph = P_IDLE;
          else begin
            m_ph   = P_HOLD;
            m_hold = HOLDOFF;
          end
        end
      end
      P_HOLD: begin
        m_hold--;
        if (m_hold == 0) m_ph = P_IDLE;
      end
      default: m_ph = P_IDLE;
    endcase
  endfunction

  task automatic drive();
    case (vmode)
      0: in_valid = 1'b1;
      1: in_valid = !in_valid;
      default: in_valid = ($urandom_range(0, 3) != 0);
    endcase
    case (rmode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 9) < 7);
    endcase
    for (int k = 0; k < N_CH; k++) begin
      case (dmode)
        0: in_data[k*IN_W +: IN_W] = IN_W'(k + 1);
        1: in_data[k*IN_W +: IN_W] = '0;
        2: in_data[k*IN_W +: IN_W] = IN_W'($urandom);
        default: in_data[k*IN_W +: IN_W] = (k == 1) ? IN_W'(-(1 << 30)) : IN_W'(k + 1);
      endcase
    end
    if (imp != 0) begin
      in_data[0 +: IN_W] = IN_W'(imp);
      imp = 0;
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      model_edge();
      @(posedge clk);
      #1;
      check("busy", busy, m_ph != P_IDLE);
      check("out_valid", out_valid, m_ph == P_OUT);
      check("trig_cnt", trig_cnt, m_trig);
      check("lost_cnt", lost_cnt, m_lost);
      if (m_ph == P_OUT) begin
        check("out_ch", out_ch, m_idx);
        check("out_q", out_q, m_q[m_idx]);
        check("out_last", out_last, m_idx == N_CH - 1);
      end
    end
  endtask

  task automatic pulse();
    tot = 4'b0001;
    cyc(1);
    tot = 4'b0000;
  endtask

  task automatic wait_ph(input ph_t p);
    int budget;
    budget = 400;
    while (m_ph != p && budget > 0) begin
      cyc(1);
      budget--;
    end
    check("reach_phase", int'(m_ph), int'(p));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_out_q"}, out_q, 0);
    check({tag, "_out_ch"}, out_ch, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_trig_cnt"}, trig_cnt, 0);
    check({tag, "_lost_cnt"}, lost_cnt, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    #1 check_cleared("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // Majority of two on the second instance.
    tot = 4'b0001; cyc(1);
    tot = 4'b0000; cyc(1);
    check("maj2_single_trig", trig_cnt2, 0);
    check("maj2_single_busy", busy2, 0);
    tot = 4'b0110; cyc(1);
    tot = 4'b0000;
    check("maj2_pair_trig", trig_cnt2, 1);
    check("maj2_pair_busy", busy2, 1);
    wait_ph(P_IDLE);
    cyc(4);

    // Constant k+1 per channel, continuous valid.
    pulse();
    wait_ph(P_IDLE);
    cyc(3);

    // Impulse exactly PRE samples before the trigger, then one further back.
    dmode = 1; cyc(6);
    imp = 100; cyc(4);
    pulse();
    wait_ph(P_IDLE);
    imp = 100; cyc(5);
    pulse();
    wait_ph(P_IDLE);

    // Alternating valid and a 10-cycle stall mid-drain.
    dmode = 2; vmode = 1; rmode = 1;
    pulse();
    wait_ph(P_OUT);
    rmode = 0; cyc(1);
    rmode = 1; cyc(10);
    rmode = 0;
    wait_ph(P_IDLE);
    vmode = 0;

    // Triggers arriving while busy are counted and dropped.
    dmode = 0;
    pulse(); cyc(4);
    pulse();
    wait_ph(P_HOLD);
    cyc(2);
    pulse();
    wait_ph(P_IDLE);
    cyc(2);

    // Coincidence held across re-entry to idle must not re-trigger.
    tot = 4'b0001;
    cyc(1);
    wait_ph(P_IDLE);
    cyc(5);
    tot = 4'b0000; cyc(2);

    // Negative full scale on channel 1.
    dmode = 3; cyc(6);
    pulse();
    wait_ph(P_IDLE);

    // Reset while words are pending.
    dmode = 2; rmode = 1;
    pulse();
    wait_ph(P_OUT);
    cyc(2);
    reset = 1'b1;
    #1 check_cleared("mid_drain_reset");
    m_ph = P_IDLE; m_cd = 1'b0; m_trig = 0; m_lost = 0; base = nv;
    #1 reset = 1'b0;
    rmode = 0;
    cyc(2);
    pulse();
    wait_ph(P_IDLE);

    // Random soak.
    vmode = 2; rmode = 2;
    for (int i = 0; i < 800; i++) begin
      tot = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'b0000;
      cyc(1);
    end
    tot = 4'b0000;
    wait_ph(P_IDLE);
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
